// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch FSM driving the PC register, instruction memory and IR handshake.
// Every output is a register loaded from the next-state/next-output logic below.
module fetch_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] pc_q,
  output logic [15:0] pc_din,
  output logic        pc_ld,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  output logic [15:0] ir,
  output logic        ir_valid,
  input  logic        ir_taken,
  input  logic        br_en,
  input  logic [15:0] br_target,
  output logic        halted
);
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, UPDATE, HALTED} state_t;
  state_t state, state_nxt;
  logic [15:0] pc_din_nxt, mem_addr_nxt, ir_nxt;
  logic        pc_ld_nxt, mem_rd_nxt, ir_valid_nxt, halted_nxt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc_din   <= '0;
      pc_ld    <= 1'b0;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      ir       <= '0;
      ir_valid <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc_din   <= pc_din_nxt;
      pc_ld    <= pc_ld_nxt;
      mem_addr <= mem_addr_nxt;
      mem_rd   <= mem_rd_nxt;
      ir       <= ir_nxt;
      ir_valid <= ir_valid_nxt;
      halted   <= halted_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? FETCH : IDLE;
      FETCH:   state_nxt = mem_ack ? HOLD : FETCH;
      HOLD:    state_nxt = !ir_taken ? HOLD : (ir == 16'hFFFF) ? HALTED : UPDATE;
      UPDATE:  state_nxt = FETCH;
      default: state_nxt = state;
    endcase
  end
  // Strobes and valid flags are pure functions of the state being entered.
  always_comb begin
    mem_rd_nxt   = state_nxt == FETCH;
    ir_valid_nxt = state_nxt == HOLD;
    pc_ld_nxt    = state_nxt == UPDATE;
    halted_nxt   = state_nxt == HALTED;
    mem_addr_nxt = (state == IDLE && start) ? pc_q : (state == UPDATE) ? pc_din : mem_addr;
    ir_nxt       = (state == FETCH && mem_ack) ? mem_data : ir;
    pc_din_nxt   = (state == HOLD && state_nxt == UPDATE) ? (br_en ? br_target : pc_q + 16'd1) : pc_din;
  end
endmodule
